writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the RISC15 pipeline: consumes the instruction, result value and flag-write strobe from the last pipeline register and commits them. Holds the architectural 8×16 register file (R7 is the PC), the carry/zero condition-code register and a retired-instruction counter. Provides two bypassed read ports for decode and a same-cycle forwarding bus for the hazard unit.

## Interface
- RESET_PC, 16'h0000, value loaded into R7 on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- IR  in  16  instruction in writeback; 16'hF000 (opcode 4'b1111) is NOP
- RF_value  in  16  result to commit
- CCRWrite  in  1  update condition codes this cycle
- carry_in  in  1  carry-out produced by the ALU for this instruction
- pc_in  in  16  next PC from fetch
- pc_write  in  1  load pc_in into R7
- rd_addr_a, rd_addr_b  in  3  decode read addresses
- rd_data_a, rd_data_b  out  16  read data, bypassed
- wb_valid  out  1  this cycle writes a register
- wb_dest  out  3  destination register
- wb_data  out  16  equals RF_value
- carry_flag, zero_flag  out  1  condition-code register
- retired_count  out  16  non-NOP instructions committed

## Operation
- Destination decode on IR[15:12], combinational:
  - 0000 ADD/ADC/ADZ, 0010 NDU/NDC/NDZ -> RC = IR[5:3]
  - 0001 ADI -> RB = IR[8:6]
  - 0011 LHI, 0100 LW, 1000 JAL, 1001 JLR -> RA = IR[11:9]
  - all other opcodes (SW, LM, SM, BEQ, NOP, unused) -> wb_valid = 0, wb_dest = 0
- LM/SM reach this stage already expanded upstream into LW/SW micro-ops; LM/SM opcodes themselves never write.
- Conditional variants (ADC/ADZ/NDC/NDZ) that failed their condition arrive as NOP; this stage does not re-evaluate cz bits.
- Register write: if wb_valid, reg[wb_dest] <= RF_value at the clock edge.
- R7 priority: wb_valid && wb_dest==7 writes RF_value; else pc_write loads pc_in; else R7 holds. Both in one cycle -> writeback wins, pc_in is dropped.
- Flags, only when CCRWrite=1:
  - zero_flag <= (RF_value == 16'h0000)
  - carry_flag <= carry_in only for opcodes 0000/0001; otherwise carry holds
  - CCRWrite=0 -> both flags hold, regardless of IR.
- Read ports: rd_data_x = RF_value when wb_valid && rd_addr_x == wb_dest, else reg[rd_addr_x]. R7 reads are bypassed from writeback only, never from pc_in.
- retired_count increments by 1 on each edge where IR[15:12] != 4'b1111; wraps 16'hFFFF -> 16'h0000.

## Timing
- Reset (reset=0): immediately, R0–R6 = 0, R7 = RESET_PC, carry_flag = zero_flag = 0, retired_count = 0. Combinational outputs follow inputs during reset, but no state changes while reset is low. Edges with reset low commit nothing.
- Reset asserted mid-cycle aborts the pending commit. First commit happens on the first rising edge with reset=1.
- Commit latency: one edge. Register, flag and counter values are visible on outputs the cycle after the edge.
- Bypass latency: zero. rd_data, wb_valid, wb_dest and wb_data are combinational from the current IR/RF_value.
- Writes to R0 are legal; no register is hard-wired.
- No stall input: every edge commits whatever is presented. The upstream register holds NOP when the stage must idle.

## Test plan
- Reset: drive reset=0 with RESET_PC=16'h0010 -> all regs 0, R7=16'h0010, flags 0, retired_count 0. Release reset, hold IR=16'hF000 for 5 cycles -> nothing changes.
- ADD R3=R1+R2 (IR=16'h0298, RC=3), RF_value=16'h0000, carry_in=1, CCRWrite=1 -> reg3=0, zero_flag=1, carry_flag=1 next cycle. Same cycle, rd_addr_a=3 reads 16'h0000 via bypass.
- NDU (IR=16'h2298) with CCRWrite=1, RF_value=16'h1234, carry_in=0, prior carry=1 -> reg3=16'h1234, zero_flag=0, carry stays 1.
- Same cycle: JAL R7 (IR=16'h8E05), RF_value=16'h0042, pc_write=1, pc_in=16'h0099 -> R7=16'h0042. Next cycle: NOP with pc_write=1 -> R7=16'h0099.
- SW, BEQ and NOP with CCRWrite=0 -> no register or flag change. retired_count advances for SW and BEQ only.
- Preload retired_count to 16'hFFFF via 65535 non-NOPs, then send one ADI -> retired_count=16'h0000. Assert reset mid-stream -> state cleared within the same cycle.

Source files
------------

// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - commit bus between the last pipeline register, decode/hazard logic and writeback
interface writeback_if;
    logic [15:0] IR;
    logic [15:0] RF_value;
    logic        CCRWrite;
    logic        carry_in;
    logic [15:0] pc_in;
    logic        pc_write;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] retired_count;

    // Pipeline / decode side: presents the instruction and read addresses, observes results
    modport master (
        output IR, RF_value, CCRWrite, carry_in, pc_in, pc_write, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_valid, wb_dest, wb_data, carry_flag, zero_flag, retired_count
    );

    // Writeback stage side
    modport slave (
        input  IR, RF_value, CCRWrite, carry_in, pc_in, pc_write, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_valid, wb_dest, wb_data, carry_flag, zero_flag, retired_count
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RISC15 writeback: register file, condition codes, retire counter
module writeback_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    writeback_if.slave  bus
);

    logic [15:0] r_regs [0:7];
    logic        r_carry;
    logic        r_zero;
    logic [15:0] r_retired;

    logic [3:0]  w_opcode;
    logic        w_wb_valid;
    logic [2:0]  w_wb_dest;
    logic        w_is_nop;
    logic        w_carry_op;
    logic        w_wb_r7;
    logic [15:0] w_rd_a;
    logic [15:0] w_rd_b;

    assign w_opcode   = bus.IR[15:12];
    assign w_is_nop   = (w_opcode == 4'b1111);
    assign w_carry_op = (w_opcode == 4'b0000) || (w_opcode == 4'b0001);
    assign w_wb_r7    = w_wb_valid && (w_wb_dest == 3'd7);

    // Destination decode; LM/SM arrive pre-expanded, so only the listed opcodes write
    always_comb begin
        w_wb_valid = 1'b0;
        w_wb_dest  = 3'd0;
        case (w_opcode)
            4'b0000, 4'b0010: begin
                w_wb_valid = 1'b1;
                w_wb_dest  = bus.IR[5:3];
            end
            4'b0001: begin
                w_wb_valid = 1'b1;
                w_wb_dest  = bus.IR[8:6];
            end
            4'b0011, 4'b0100, 4'b1000, 4'b1001: begin
                w_wb_valid = 1'b1;
                w_wb_dest  = bus.IR[11:9];
            end
            default: begin
                w_wb_valid = 1'b0;
                w_wb_dest  = 3'd0;
            end
        endcase
    end

    // Register file commit; a writeback to R7 takes precedence over the fetch PC load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 7; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_regs[7] <= RESET_PC;
        end else begin
            if (w_wb_valid) begin
                r_regs[w_wb_dest] <= bus.RF_value;
            end
            if (bus.pc_write && !w_wb_r7) begin
                r_regs[7] <= bus.pc_in;
            end
        end
    end

    // Condition codes: zero from any flag-writing result, carry only from ADD-class and ADI
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (bus.CCRWrite) begin
            r_zero <= (bus.RF_value == 16'h0000);
            if (w_carry_op) begin
                r_carry <= bus.carry_in;
            end
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= 16'h0000;
        end else if (!w_is_nop) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    // Read ports bypass the in-flight result; pc_in is never forwarded
    always_comb begin
        w_rd_a = r_regs[bus.rd_addr_a];
        w_rd_b = r_regs[bus.rd_addr_b];
        if (w_wb_valid && (bus.rd_addr_a == w_wb_dest)) begin
            w_rd_a = bus.RF_value;
        end
        if (w_wb_valid && (bus.rd_addr_b == w_wb_dest)) begin
            w_rd_b = bus.RF_value;
        end
    end

    assign bus.rd_data_a     = w_rd_a;
    assign bus.rd_data_b     = w_rd_b;
    assign bus.wb_valid      = w_wb_valid;
    assign bus.wb_dest       = w_wb_dest;
    assign bus.wb_data       = bus.RF_value;
    assign bus.carry_flag    = r_carry;
    assign bus.zero_flag     = r_zero;
    assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    writeback_if bus ();

    writeback_stage #(.RESET_PC(16'h0010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Architectural model state
    logic [15:0] m_regs [0:7];
    logic        m_c;
    logic        m_z;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Which register an instruction names as its destination, by opcode table
    function automatic logic [3:0] dest_of(input logic [15:0] ir);
        case (ir[15:12])
            4'd0, 4'd2:             return {1'b1, ir[5:3]};
            4'd1:                   return {1'b1, ir[8:6]};
            4'd3, 4'd4, 4'd8, 4'd9: return {1'b1, ir[11:9]};
            default:                return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [3:0] d;
        d = dest_of(bus.IR);
        if (d[3] && d[2:0] == a) return bus.RF_value;
        return m_regs[a];
    endfunction

    // Model commit: what the architecture must hold after each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
            m_regs[7] <= 16'h0010;
            m_c   <= 1'b0;
            m_z   <= 1'b0;
            m_cnt <= 16'h0000;
        end else begin
            logic [3:0] d;
            d = dest_of(bus.IR);
            if (bus.pc_write) m_regs[7] <= bus.pc_in;
            if (d[3]) m_regs[d[2:0]] <= bus.RF_value;
            if (bus.CCRWrite) begin
                m_z <= (bus.RF_value == 16'h0000);
                if (bus.IR[15:12] <= 4'd1) m_c <= bus.carry_in;
            end
            if (bus.IR[15:12] != 4'hF) m_cnt <= m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] d;
        d = dest_of(bus.IR);
        chk("wb_valid", {15'd0, bus.wb_valid}, {15'd0, d[3]});
        chk("wb_dest", {13'd0, bus.wb_dest}, {13'd0, d[2:0]});
        chk("wb_data", bus.wb_data, bus.RF_value);
        chk("rd_data_a", bus.rd_data_a, model_read(bus.rd_addr_a));
        chk("rd_data_b", bus.rd_data_b, model_read(bus.rd_addr_b));
        chk("carry_flag", {15'd0, bus.carry_flag}, {15'd0, m_c});
        chk("zero_flag", {15'd0, bus.zero_flag}, {15'd0, m_z});
        chk("retired_count", bus.retired_count, m_cnt);
    end

    task automatic drive(input logic [15:0] ir, input logic [15:0] val, input logic ccr,
                         input logic cin, input logic pcw, input logic [15:0] pcin,
                         input logic [2:0] ra, input logic [2:0] rb);
        @(posedge clk);
        #2;
        bus.IR        = ir;
        bus.RF_value  = val;
        bus.CCRWrite  = ccr;
        bus.carry_in  = cin;
        bus.pc_write  = pcw;
        bus.pc_in     = pcin;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
    endtask

    task automatic at_sample;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.IR        = 16'hF000;
        bus.RF_value  = 16'h0000;
        bus.CCRWrite  = 1'b0;
        bus.carry_in  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_in     = 16'h0000;
        bus.rd_addr_a = 3'd7;
        bus.rd_addr_b = 3'd3;
        #1 reset = 1'b0;

        // Reset state
        at_sample;
        chk("rst_r7", bus.rd_data_a, 16'h0010);
        chk("rst_r3", bus.rd_data_b, 16'h0000);
        chk("rst_cnt", bus.retired_count, 16'h0000);
        chk("rst_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0000);

        // Release, then idle on NOPs
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (5) drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd7, 3'd3);
        at_sample;
        chk("idle_cnt", bus.retired_count, 16'h0000);
        chk("idle_r7", bus.rd_data_a, 16'h0010);

        // ADD R3, zero result, carry out
        drive(16'h0298, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0, 3'd3, 3'd1);
        at_sample;
        chk("add_bypass", bus.rd_data_a, 16'h0000);
        chk("add_dest", {13'd0, bus.wb_dest}, 16'd3);

        // NDU R3: zero clears, carry holds
        drive(16'h2298, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 3'd3, 3'd1);
        at_sample;
        chk("ndu_bypass", bus.rd_data_a, 16'h1234);
        chk("add_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0003);
        chk("add_cnt", bus.retired_count, 16'h0001);

        // JAL R7 collides with pc_write: writeback wins
        drive(16'h8E05, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h0099, 3'd7, 3'd3);
        at_sample;
        chk("jal_bypass", bus.rd_data_a, 16'h0042);
        chk("ndu_r3", bus.rd_data_b, 16'h1234);
        chk("ndu_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0002);

        // NOP with pc_write loads the PC
        drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0099, 3'd7, 3'd3);
        at_sample;
        chk("jal_r7", bus.rd_data_a, 16'h0042);
        chk("jal_cnt", bus.retired_count, 16'h0003);

        // SW, BEQ, NOP without flag writes
        drive(16'h5E05, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0, 3'd7, 3'd3);
        at_sample;
        chk("pc_r7", bus.rd_data_a, 16'h0099);
        chk("sw_valid", {15'd0, bus.wb_valid}, 16'd0);
        drive(16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd7, 3'd3);
        drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd7, 3'd3);
        at_sample;
        chk("sw_beq_cnt", bus.retired_count, 16'h0005);
        chk("sw_beq_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0002);

        // Walk the counter up to 16'hFFFF with SWs
        for (int i = 0; i < 65530; i++) begin
            drive(16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 3'd7);
        end
        drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 3'd7);
        at_sample;
        chk("cnt_max", bus.retired_count, 16'hFFFF);

        // ADI R5 wraps the counter; a parallel pc_write still lands in R7
        drive(16'h1140, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h0077, 3'd5, 3'd7);
        drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 3'd7);
        at_sample;
        chk("cnt_wrap", bus.retired_count, 16'h0000);
        chk("adi_r5", bus.rd_data_a, 16'hABCD);
        chk("adi_r7_pc", bus.rd_data_b, 16'h0077);
        chk("adi_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0000);

        // Reset mid-cycle aborts the pending ADD and clears state at once
        drive(16'h0298, 16'h5555, 1'b1, 1'b1, 1'b0, 16'h0, 3'd7, 3'd5);
        #1 reset = 1'b0;
        at_sample;
        chk("mid_rst_r7", bus.rd_data_a, 16'h0010);
        chk("mid_rst_r5", bus.rd_data_b, 16'h0000);
        chk("mid_rst_cnt", bus.retired_count, 16'h0000);
        @(posedge clk);
        at_sample;
        chk("rst_hold_cnt", bus.retired_count, 16'h0000);
        chk("rst_hold_flags", {14'd0, bus.carry_flag, bus.zero_flag}, 16'h0000);
        drive(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd3, 3'd5);
        reset = 1'b1;
        at_sample;
        chk("post_rst_r3", bus.rd_data_a, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
